// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared state, opcode, condition and mux-select encodings for the multicycle controller
package multicycle_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
    localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;
    localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                           CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
                           COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
                           COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
                           COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111;

    localparam logic       ADR_PC = 1'b0, ADR_ALUOUT = 1'b1;
    localparam logic [1:0] SRCA_REG = 2'b00, SRCA_PC = 2'b01;
    localparam logic [1:0] SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;

    // CMP shares the subtractor; unknown commands fall back to ADD and are trapped by the decoder
    function automatic logic [1:0] alu_ctl(input logic [3:0] cmd);
        return (cmd == CMD_ADD) ? ALU_ADD :
               (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
               (cmd == CMD_AND) ? ALU_AND :
               (cmd == CMD_ORR) ? ALU_ORR : ALU_ADD;
    endfunction
endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// cond_unit: NZCV flag register and ARM condition-code evaluation against the stored flags
module cond_unit
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_flag_req,
    input  logic       i_cv_we,
    output logic       o_cond_ex
);
    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_ff @(posedge clk)
        if (!reset)
            r_flags <= '0;
        else if (i_flag_req && o_cond_ex)
            r_flags <= {i_alu_flags[3:2], i_cv_we ? i_alu_flags[1:0] : r_flags[1:0]};

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !w_c || w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = !w_z && (w_n == w_v);
            COND_LE: o_cond_ex = w_z || (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore main FSM and decoder for the multicycle ARM subset; MULTICYCLE_CMP_EN enables CMP
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUControl,
    output logic [STATE_W-1:0] state
);
    state_t     r_state;
    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op, w_alu_dp;
    logic [5:0] w_funct;
    logic       w_i, w_s, w_l, w_store, w_cmd_ok, w_cmp, w_illegal;
    logic       w_cond_ex, w_flag_req, w_cv_we, w_rd_pc;
    logic       w_pcw, w_memw, w_regw, w_irw;
    logic       w_unused;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_rd     = Instr[3:0];
    assign w_unused = ^Instr[7:4];
    assign w_i      = w_funct[5];
    assign w_cmd    = w_funct[4:1];
    assign w_s      = w_funct[0];
    assign w_l      = w_funct[0];
    assign w_store  = (w_op == OP_MEM) && !w_l;
    assign w_rd_pc  = (w_rd == 4'hF);
    assign w_alu_dp = alu_ctl(w_cmd);
    assign w_cmd_ok = (w_cmd == CMD_ADD) || (w_cmd == CMD_SUB) || (w_cmd == CMD_AND) || (w_cmd == CMD_ORR);
`ifdef MULTICYCLE_CMP_EN
    assign w_cmp    = (w_op == OP_DP) && (w_cmd == CMD_CMP) && w_s;
`else
    assign w_cmp    = 1'b0;
`endif
    assign w_illegal  = (w_op == 2'b11) || ((w_op == OP_DP) && !w_cmd_ok && !w_cmp);
    assign w_flag_req = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) && w_s;
    assign w_cv_we    = (w_alu_dp == ALU_ADD) || (w_alu_dp == ALU_SUB);

    cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .i_cond     (w_cond),
        .i_alu_flags(ALUFlags),
        .i_flag_req (w_flag_req),
        .i_cv_we    (w_cv_we),
        .o_cond_ex  (w_cond_ex)
    );

    always_ff @(posedge clk)
        if (!reset)
            r_state <= S_FETCH;
        else
            case (r_state)
                S_FETCH:    r_state <= S_DECODE;
                S_DECODE:   r_state <= w_illegal ? S_UNKNOWN :
                                       (w_op == OP_MEM) ? S_MEMADR :
                                       (w_op == OP_BR) ? S_BRANCH :
                                       w_i ? S_EXECUTEI : S_EXECUTER;
                S_MEMADR:   r_state <= w_l ? S_MEMRD : S_MEMWR;
                S_MEMRD:    r_state <= S_MEMWB;
                S_EXECUTER,
                S_EXECUTEI: r_state <= w_cmp ? S_FETCH : S_ALUWB;
                default:    r_state <= S_FETCH;
            endcase

    always_comb begin
        w_pcw      = 1'b0;
        w_memw     = 1'b0;
        w_regw     = 1'b0;
        w_irw      = 1'b0;
        AdrSrc     = ADR_PC;
        RegSrc     = {w_store, 1'b0};
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMRD:    AdrSrc = ADR_ALUOUT;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                w_regw    = w_cond_ex;
                w_pcw     = w_cond_ex && w_rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = ADR_ALUOUT;
                w_memw = w_cond_ex;
            end
            S_EXECUTER: ALUControl = w_alu_dp;
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = w_alu_dp;
            end
            S_ALUWB: begin
                w_regw = w_cond_ex;
                w_pcw  = w_cond_ex && w_rd_pc;
            end
            S_BRANCH: begin
                RegSrc[0] = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                w_pcw     = w_cond_ex;
            end
            default: ;
        endcase
    end

    // reset suppresses every write in the same cycle it is asserted
    assign PCWrite  = reset && w_pcw;
    assign MemWrite = reset && w_memw;
    assign RegWrite = reset && w_regw;
    assign IRWrite  = reset && w_irw;
    assign ImmSrc   = w_op;
    assign state    = STATE_W'(r_state);
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences with hand-computed state and control expectations
module tb_multicycle_controller;
    import multicycle_pkg::*;

    logic        clk, reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  state;
    int          checks = 0;
    int          failures = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Instr = 20'hE5921;
        ALUFlags = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_writes[%0d] got=%b exp=0000", i, {PCWrite, MemWrite, RegWrite, IRWrite});
            end
            checks++;
            if (state !== 4'(S_FETCH)) begin
                failures++;
                $display("FAIL reset_state[%0d] got=%0d exp=%0d", i, state, 4'(S_FETCH));
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({state, IRWrite, PCWrite} !== {4'(S_FETCH), 2'b11}) begin
            failures++;
            $display("FAIL release_fetch got state=%0d ir=%b pc=%b exp state=0 ir=1 pc=1", state, IRWrite, PCWrite);
        end
    endtask

    task automatic test_ldr();
        state_t seq [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        Instr = 20'hE5921;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 4'(seq[i])) begin
                failures++;
                $display("FAIL ldr_state[%0d] got=%0d exp=%0d", i, state, 4'(seq[i]));
            end
            checks++;
            if (RegWrite !== (i == 4)) begin
                failures++;
                $display("FAIL ldr_regwrite[%0d] got=%b exp=%b", i, RegWrite, (i == 4));
            end
            if (i == 2) begin
                checks++;
                if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b00_01_01) begin
                    failures++;
                    $display("FAIL ldr_memadr got=%b exp=000101", {ALUSrcA, ALUSrcB, ImmSrc});
                end
            end
            if (i == 3) begin
                checks++;
                if (AdrSrc !== 1'b1) begin
                    failures++;
                    $display("FAIL ldr_memrd_adrsrc got=%b exp=1", AdrSrc);
                end
            end
            if (i == 4) begin
                checks++;
                if ({ResultSrc, PCWrite} !== 3'b01_0) begin
                    failures++;
                    $display("FAIL ldr_memwb got=%b exp=010", {ResultSrc, PCWrite});
                end
            end
            step();
        end
    endtask

    task automatic test_subs_beq();
        state_t dp [4] = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
        state_t br [3] = '{S_FETCH, S_DECODE, S_BRANCH};
        Instr = 20'hE0533;
        ALUFlags = 4'b0100;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(dp[i])) begin
                failures++;
                $display("FAIL subs_state[%0d] got=%0d exp=%0d", i, state, 4'(dp[i]));
            end
            if (i == 2) begin
                checks++;
                if ({ALUControl, ALUSrcB} !== 4'b01_00) begin
                    failures++;
                    $display("FAIL subs_exec got=%b exp=0100", {ALUControl, ALUSrcB});
                end
            end
            if (i == 3) begin
                checks++;
                if ({RegWrite, PCWrite} !== 2'b10) begin
                    failures++;
                    $display("FAIL subs_aluwb got=%b exp=10", {RegWrite, PCWrite});
                end
            end
            step();
        end
        ALUFlags = 4'b0000;
        Instr = 20'h0A000;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'(br[i])) begin
                failures++;
                $display("FAIL beq_state[%0d] got=%0d exp=%0d", i, state, 4'(br[i]));
            end
            checks++;
            if (PCWrite !== (i != 1)) begin
                failures++;
                $display("FAIL beq_pcwrite[%0d] got=%b exp=%b", i, PCWrite, (i != 1));
            end
            if (i == 2) begin
                checks++;
                if (RegSrc !== 2'b01) begin
                    failures++;
                    $display("FAIL beq_regsrc got=%b exp=01", RegSrc);
                end
            end
            step();
        end
    endtask

    task automatic test_bne();
        state_t br [3] = '{S_FETCH, S_DECODE, S_BRANCH};
        Instr = 20'h1A000;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'(br[i])) begin
                failures++;
                $display("FAIL bne_state[%0d] got=%0d exp=%0d", i, state, 4'(br[i]));
            end
            checks++;
            if (PCWrite !== (i == 0)) begin
                failures++;
                $display("FAIL bne_pcwrite[%0d] got=%b exp=%b", i, PCWrite, (i == 0));
            end
            step();
        end
        checks++;
        if (state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL bne_return got=%0d exp=%0d", state, 4'(S_FETCH));
        end
    endtask

    task automatic test_add_pc();
        state_t dp [4] = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
        Instr = 20'hE080F;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(dp[i])) begin
                failures++;
                $display("FAIL addpc_state[%0d] got=%0d exp=%0d", i, state, 4'(dp[i]));
            end
            if (i == 2) begin
                checks++;
                if ({ALUControl, ALUSrcA, ALUSrcB} !== 6'b00_00_00) begin
                    failures++;
                    $display("FAIL addpc_exec got=%b exp=000000", {ALUControl, ALUSrcA, ALUSrcB});
                end
            end
            if (i == 3) begin
                checks++;
                if ({RegWrite, PCWrite, ResultSrc} !== 4'b11_00) begin
                    failures++;
                    $display("FAIL addpc_aluwb got=%b exp=1100", {RegWrite, PCWrite, ResultSrc});
                end
            end
            step();
        end
    endtask

    task automatic test_store();
        state_t st [4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
        logic [19:0] ins [2] = '{20'hE5821, 20'h15821};
        for (int k = 0; k < 2; k++) begin
            Instr = ins[k];
            #1;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (state !== 4'(st[i])) begin
                    failures++;
                    $display("FAIL str%0d_state[%0d] got=%0d exp=%0d", k, i, state, 4'(st[i]));
                end
                checks++;
                if (MemWrite !== (i == 3 && k == 0)) begin
                    failures++;
                    $display("FAIL str%0d_memwrite[%0d] got=%b exp=%b", k, i, MemWrite, (i == 3 && k == 0));
                end
                if (i == 2 || i == 3) begin
                    checks++;
                    if ({RegSrc[1], AdrSrc} !== {1'b1, (i == 3)}) begin
                        failures++;
                        $display("FAIL str%0d_sel[%0d] got=%b exp=%b", k, i, {RegSrc[1], AdrSrc}, {1'b1, (i == 3)});
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_flags_cv();
        state_t dp [4] = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
        logic [19:0] br [3] = '{20'h2A000, 20'h4A000, 20'hFA000};
        logic        pcw [3] = '{1'b0, 1'b1, 1'b0};
        Instr = 20'hE0100;
        ALUFlags = 4'b1011;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(dp[i])) begin
                failures++;
                $display("FAIL ands_state[%0d] got=%0d exp=%0d", i, state, 4'(dp[i]));
            end
            if (i == 2) begin
                checks++;
                if (ALUControl !== 2'b10) begin
                    failures++;
                    $display("FAIL ands_alucontrol got=%b exp=10", ALUControl);
                end
            end
            step();
        end
        ALUFlags = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            Instr = br[k];
            step();
            step();
            checks++;
            if ({state, PCWrite} !== {4'(S_BRANCH), pcw[k]}) begin
                failures++;
                $display("FAIL cond_branch[%0d] got state=%0d pc=%b exp state=%0d pc=%b", k, state, PCWrite, 4'(S_BRANCH), pcw[k]);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        state_t seq [3] = '{S_FETCH, S_DECODE, S_UNKNOWN};
        Instr = 20'hEC000;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'(seq[i])) begin
                failures++;
                $display("FAIL illegal_state[%0d] got=%0d exp=%0d", i, state, 4'(seq[i]));
            end
            checks++;
            if ({PCWrite, MemWrite, RegWrite} !== {(i == 0), 2'b00}) begin
                failures++;
                $display("FAIL illegal_writes[%0d] got=%b exp=%b", i, {PCWrite, MemWrite, RegWrite}, {(i == 0), 2'b00});
            end
            step();
        end
        checks++;
        if (state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL illegal_return got=%0d exp=%0d", state, 4'(S_FETCH));
        end
    endtask

    task automatic test_cmp();
`ifdef MULTICYCLE_CMP_EN
        state_t seq [3] = '{S_FETCH, S_DECODE, S_EXECUTEI};
`else
        state_t seq [3] = '{S_FETCH, S_DECODE, S_UNKNOWN};
`endif
        Instr = 20'hE3530;
        ALUFlags = 4'b0100;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'(seq[i])) begin
                failures++;
                $display("FAIL cmp_state[%0d] got=%0d exp=%0d", i, state, 4'(seq[i]));
            end
            checks++;
            if ({MemWrite, RegWrite} !== 2'b00) begin
                failures++;
                $display("FAIL cmp_writes[%0d] got=%b exp=00", i, {MemWrite, RegWrite});
            end
            step();
        end
        ALUFlags = 4'b0000;
        checks++;
        if (state !== 4'(S_FETCH)) begin
            failures++;
            $display("FAIL cmp_return got=%0d exp=%0d", state, 4'(S_FETCH));
        end
    endtask

    task automatic test_reset_mid();
        Instr = 20'hE5921;
        #1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({state, RegWrite} !== {4'(S_MEMWB), 1'b1}) begin
            failures++;
            $display("FAIL mid_pre got state=%0d rw=%b exp state=%0d rw=1", state, RegWrite, 4'(S_MEMWB));
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_suppress got=%b exp=0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        step();
        checks++;
        if ({state, IRWrite} !== {4'(S_FETCH), 1'b0}) begin
            failures++;
            $display("FAIL mid_held got state=%0d ir=%b exp state=0 ir=0", state, IRWrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({state, IRWrite, PCWrite} !== {4'(S_FETCH), 2'b11}) begin
            failures++;
            $display("FAIL mid_release got state=%0d ir=%b pc=%b exp state=0 ir=1 pc=1", state, IRWrite, PCWrite);
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_subs_beq();
        test_bne();
        test_add_pc();
        test_store();
        test_flags_cv();
        test_illegal();
        test_cmp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
